// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared defaults and state encoding for the FIFO word packer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DATA_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// ============================================================================
// Module : fifo_word_packer
// Brief  : Drains an 8-bit FIFO one byte per cycle and packs bytes into words
//          offered on a valid/ready handshake; flush emits a partial word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_word_packer #(
    parameter int DATA_W         = fifo_pkg::DATA_W,
    parameter int BYTES_PER_WORD = fifo_pkg::BYTES_PER_WORD
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 fifo_empty,
    input  logic [DATA_W-1:0]                    fifo_data,
    output logic                                 read_en,
    input  logic                                 flush,
    output logic [DATA_W*BYTES_PER_WORD-1:0]     word,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]  word_bytes,
    output logic                                 word_valid,
    input  logic                                 word_ready
);

    import fifo_pkg::*;

    localparam int               CNT_W      = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(BYTES_PER_WORD);

    pack_state_e                              state_q, state_d;
    logic [CNT_W-1:0]                         issued_q, issued_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic                                     pend_q, pend_d;
    logic                                     flush_req_q, flush_req_d;
    logic [BYTES_PER_WORD-1:0][DATA_W-1:0]    lanes_q, lanes_d;

    // Never read speculatively: an empty FIFO blocks the strobe in the same cycle.
    assign read_en = (state_q == FILL) && !fifo_empty &&
                     (issued_q < C_FULL_CNT) && !flush_req_q;

    assign word       = lanes_q;
    assign word_valid = (state_q == HOLD);
    assign word_bytes = (state_q == HOLD) ? cnt_q : '0;

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        cnt_d       = cnt_q;
        pend_d      = read_en;
        flush_req_d = flush_req_q | flush;
        lanes_d     = lanes_q;

        if (read_en) begin
            issued_d = issued_q + CNT_W'(1);
        end

        if (pend_q) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    lanes_d[i] = fifo_data;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            FILL: begin
                if (pend_q && (cnt_d == C_FULL_CNT)) begin
                    state_d     = HOLD;
                    flush_req_d = 1'b0;
                end else if (flush_req_q && !pend_q) begin
                    // Flush waits for any in-flight byte; an empty buffer flushes silently.
                    if (cnt_q != '0) begin
                        state_d = HOLD;
                    end
                    flush_req_d = 1'b0;
                end
            end
            HOLD: begin
                // A flush seen while holding survives the handshake.
                if (word_ready) begin
                    state_d  = FILL;
                    issued_d = '0;
                    cnt_d    = '0;
                    lanes_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            issued_q    <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            lanes_q     <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            flush_req_q <= flush_req_d;
            lanes_q     <= lanes_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ============================================================================
// Module : tb_fifo_word_packer
// Brief  : Directed bench for fifo_word_packer with a small behavioural FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_word_packer;

    localparam int DW  = 8;
    localparam int BPW = 4;
    localparam int WW  = DW * BPW;
    localparam int CW  = $clog2(BPW + 1);

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data  = '0;
    logic          read_en;
    logic          flush      = 1'b0;
    logic [WW-1:0] word;
    logic [CW-1:0] word_bytes;
    logic          word_valid;
    logic          word_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [0:63];
    int   wr_ptr    = 0;
    int   rd_ptr    = 0;
    int   cyc       = 0;
    int   underflow = 0;
    logic gap_en    = 1'b0;

    always #5 clk = ~clk;

    // Optional forced-empty every other cycle exercises the no-speculation rule.
    assign fifo_empty = (rd_ptr == wr_ptr) || (gap_en && cyc[0]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (read_en) begin
            if (fifo_empty) begin
                underflow <= underflow + 1;
            end else begin
                fifo_data <= mem[rd_ptr[5:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    fifo_word_packer #(
        .DATA_W         (DW),
        .BYTES_PER_WORD (BPW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .read_en    (read_en),
        .flush      (flush),
        .word       (word),
        .word_bytes (word_bytes),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr++;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!word_valid && n < 40);
        if (!word_valid) check_val({tag, " timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int held_rd;
        int seen_valid;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst read_en", read_en, 0);
        check_val("rst word_valid", word_valid, 0);
        check_val("rst word", word, 0);
        check_val("rst word_bytes", word_bytes, 0);
        reset = 1'b0;

        // Full word, ready held high: reads in cycles 0..3, valid in cycle 5 only
        next_cyc();
        for (int i = 0; i < 4; i++) push(8'(17 * (i + 1)));
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check_val($sformatf("t1 read_en c%0d", c), read_en, (c < 4) ? 1 : 0);
            check_val($sformatf("t1 valid c%0d", c), word_valid, (c == 5) ? 1 : 0);
            if (c == 5) begin
                check_val("t1 word", word, 64'h44332211);
                check_val("t1 bytes", word_bytes, 4);
            end
        end

        // Back-pressure: word held stable, no reads while held
        next_cyc();
        word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        held_rd = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c >= 4 && read_en) held_rd++;
            if (c == 5) check_val("t2 first word", word, 64'h04030201);
        end
        check_val("t2 held word", word, 64'h04030201);
        check_val("t2 held bytes", word_bytes, 4);
        check_val("t2 held valid", word_valid, 1);
        check_val("t2 reads while held", held_rd, 0);
        word_ready = 1'b1;
        @(negedge clk);
        check_val("t2 read after handshake", read_en, 1);
        check_val("t2 valid dropped", word_valid, 0);
        wait_valid("t2 second");
        check_val("t2 second word", word, 64'h08070605);
        check_val("t2 second bytes", word_bytes, 4);

        // Empty toggling during fill
        next_cyc();
        gap_en = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(8'hA0 + i));
        wait_valid("t3");
        check_val("t3 word", word, 64'hA4A3A2A1);
        check_val("t3 bytes", word_bytes, 4);
        gap_en = 1'b0;

        // Flush with two buffered bytes, nothing in flight
        next_cyc();
        push(8'hAA);
        push(8'hBB);
        repeat (3) next_cyc();
        flush = 1'b1;
        next_cyc();
        flush = 1'b0;
        @(negedge clk);
        check_val("t4 valid t+1", word_valid, 0);
        @(negedge clk);
        check_val("t4 valid t+2", word_valid, 1);
        check_val("t4 word", word, 64'h0000BBAA);
        check_val("t4 bytes", word_bytes, 2);

        // Flush with an empty buffer produces nothing
        next_cyc();
        flush = 1'b1;
        next_cyc();
        flush = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (word_valid) seen_valid++;
        end
        check_val("t4 empty flush valid", seen_valid, 0);

        // Flush in the cycle of the 2nd read: in-flight byte kept, third byte left queued
        next_cyc();
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        next_cyc();
        flush = 1'b1;
        next_cyc();
        flush = 1'b0;
        @(negedge clk);
        check_val("t5 valid c2", word_valid, 0);
        @(negedge clk);
        check_val("t5 valid c3", word_valid, 0);
        @(negedge clk);
        check_val("t5 valid c4", word_valid, 1);
        check_val("t5 word", word, 64'h0000C2C1);
        check_val("t5 bytes", word_bytes, 2);
        @(negedge clk);
        check_val("t5 leftover read", read_en, 1);
        next_cyc();
        flush = 1'b1;
        next_cyc();
        flush = 1'b0;
        wait_valid("t5 leftover");
        check_val("t5 leftover word", word, 64'h000000C3);
        check_val("t5 leftover bytes", word_bytes, 1);

        // Asynchronous reset with three bytes captured
        next_cyc();
        push(8'hD1);
        push(8'hD2);
        push(8'hD3);
        repeat (4) next_cyc();
        #2 reset = 1'b1;
        #1;
        check_val("t6 fill rst word", word, 0);
        check_val("t6 fill rst valid", word_valid, 0);
        check_val("t6 fill rst bytes", word_bytes, 0);
        @(negedge clk);
        reset = 1'b0;
        next_cyc();
        for (int i = 1; i <= 4; i++) push(8'(8'hE0 + i));
        wait_valid("t6 after fill rst");
        check_val("t6 after fill rst word", word, 64'hE4E3E2E1);
        check_val("t6 after fill rst bytes", word_bytes, 4);

        // Asynchronous reset while holding a word
        next_cyc();
        word_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(8'hF0 + i));
        wait_valid("t6 hold");
        check_val("t6 hold word", word, 64'hF4F3F2F1);
        #2 reset = 1'b1;
        #1;
        check_val("t6 hold rst word", word, 0);
        check_val("t6 hold rst valid", word_valid, 0);
        #1 reset = 1'b0;
        word_ready = 1'b1;
        next_cyc();
        for (int i = 1; i <= 4; i++) push(8'(8'h90 + i));
        wait_valid("t6 after hold rst");
        check_val("t6 after hold rst word", word, 64'h94939291);

        next_cyc();
        check_val("no underflow", underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
